// File: rtl/cm0_fetch_pkg.sv
// Shared types and constants for the Thumb fetch stage.
package cm0_fetch_pkg;

    localparam int PC_WIDTH = 15;   // halfword PC width
    localparam int IR_WIDTH = 16;   // one Thumb halfword

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // IR_0 output-mux selects of the dual-bank ROM
    localparam logic [1:0] SEL0_BANK0 = 2'd0;
    localparam logic [1:0] SEL0_IR1   = 2'd1;
    localparam logic [1:0] SEL0_BANK1 = 2'd2;

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [PC_WIDTH-1:0] pc;
    } q_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch-stage bus: ROM address/select/data, branch redirect and decode queue view.
interface fetch_queue_ctrl_if #(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 15
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [PC_W-2:0]  rom_addr;
    logic             rom_pc_1;
    logic             rom_sel_mem_1;
    logic [1:0]       rom_sel_mem_0;
    logic [15:0]      rom_ir_0;
    logic [15:0]      rom_ir_1;
    logic             br_valid;
    logic [PC_W-1:0]  br_target;
    logic [1:0]       dec_pop;
    logic [1:0]       dec_valid;
    logic [15:0]      dec_ir_0;
    logic [15:0]      dec_ir_1;
    logic [PC_W-1:0]  dec_pc_0;
    logic [CNT_W-1:0] q_count;

    // Fetch controller side
    modport master (
        output rom_addr, rom_pc_1, rom_sel_mem_1, rom_sel_mem_0,
        input  rom_ir_0, rom_ir_1,
        input  br_valid, br_target, dec_pop,
        output dec_valid, dec_ir_0, dec_ir_1, dec_pc_0, q_count
    );

    // ROM / branch unit / decode side
    modport slave (
        input  rom_addr, rom_pc_1, rom_sel_mem_1, rom_sel_mem_0,
        output rom_ir_0, rom_ir_1,
        output br_valid, br_target, dec_pop,
        input  dec_valid, dec_ir_0, dec_ir_1, dec_pc_0, q_count
    );

endinterface

// File: rtl/fetch_iq.sv
// Instruction queue: 2-wide push, 0..2 pop, synchronous clear; exposes head and head+1.
module fetch_iq
    import cm0_fetch_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  q_entry_t         wr_0,
    input  q_entry_t         wr_1,
    input  logic [1:0]       pop,
    output q_entry_t         head_0,
    output q_entry_t         head_1,
    output logic [CNT_W-1:0] count,
    output logic             room_2
);
    localparam int PTR_W = $clog2(QDEPTH);

    q_entry_t         mem_q [QDEPTH];
    q_entry_t         mem_d [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pop_ext, pop_eff;

    // Clamp the pop to what is held, then derive post-pop room and next pointers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        pop_ext = CNT_W'(pop);
        pop_eff = (pop_ext > count_q) ? count_q : pop_ext;
        room_2  = (CNT_W'(QDEPTH) - (count_q - pop_eff)) >= CNT_W'(2);

        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
            count_d  = count_q - pop_eff;
            if (push) begin
                mem_d[wr_ptr_q]              = wr_0;
                mem_d[wr_ptr_q + PTR_W'(1)]  = wr_1;
                wr_ptr_d                     = wr_ptr_q + PTR_W'(2);
                count_d                      = count_d + CNT_W'(2);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q gates every read, so stale entries are never seen.
        mem_q <= mem_d;
    end

    assign head_0 = mem_q[rd_ptr_q];
    assign head_1 = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count  = count_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch stage: owns the halfword PC, drives the dual-bank ROM, fills the decode queue.
module fetch_queue_ctrl
    import cm0_fetch_pkg::*;
#(
    parameter int              QDEPTH   = 4,
    parameter int              PC_W     = PC_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             iq_clr;
    logic             iq_push;
    logic [1:0]       iq_pop;
    logic             room_2;
    q_entry_t         wr_0, wr_1, head_0, head_1;
    logic [CNT_W-1:0] count;

    // Redirect beats everything; otherwise BOOT/FLUSH burn one cycle and RUN fetches when two slots free.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iq_clr  = 1'b0;
        iq_push = 1'b0;
        iq_pop  = bus.dec_pop;
        if (bus.br_valid) begin
            iq_clr  = 1'b1;
            iq_pop  = 2'd0;
            pc_d    = bus.br_target;
            state_d = FLUSH;
        end else begin
            case (state_q)
                BOOT, FLUSH: state_d = RUN;
                RUN: begin
                    if (room_2) begin
                        iq_push = 1'b1;
                        pc_d    = pc_q + PC_W'(2);
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign wr_0 = '{ir: bus.rom_ir_0, pc: pc_q};
    assign wr_1 = '{ir: bus.rom_ir_1, pc: pc_q + PC_W'(1)};

    fetch_iq #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_iq (
        .clk    (clk),
        .rst    (rst),
        .clr    (iq_clr),
        .push   (iq_push),
        .wr_0   (wr_0),
        .wr_1   (wr_1),
        .pop    (iq_pop),
        .head_0 (head_0),
        .head_1 (head_1),
        .count  (count),
        .room_2 (room_2)
    );

    // Odd PC: bank 0 supplies the second halfword from row+1, so IR_0 comes from bank 1.
    assign bus.rom_addr      = pc_q[PC_W-1:1];
    assign bus.rom_pc_1      = pc_q[0];
    assign bus.rom_sel_mem_1 = ~pc_q[0];
    assign bus.rom_sel_mem_0 = pc_q[0] ? SEL0_BANK1 : SEL0_BANK0;

    // Decode view; slots beyond the occupancy read as zero.
    assign bus.dec_valid = {count >= CNT_W'(2), count >= CNT_W'(1)};
    assign bus.dec_ir_0  = (count >= CNT_W'(1)) ? head_0.ir : '0;
    assign bus.dec_pc_0  = (count >= CNT_W'(1)) ? head_0.pc : '0;
    assign bus.dec_ir_1  = (count >= CNT_W'(2)) ? head_1.ir : '0;
    assign bus.q_count   = count;

endmodule
